mem_access_sequencer: RTL

//   Two-requester memory access sequencer in front of the 12-register / RAM address space.

---
 rtl/mem_access_sequencer_if.sv | 40 ++++
 rtl/mem_access_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mem_access_sequencer_if.sv
// Bus bundle between the two requesters, the sequencer and the register bank / RAM.
// The master side is the requesters plus the memory-side data returns. The slave side is the sequencer.
interface mem_access_sequencer_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata;
    logic [AW-1:0] add;
    logic [DW-1:0] wdata;
    logic          reg_we;
    logic [DW-1:0] reg_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [DW-1:0] ram_rdata;
    logic          busy;

    modport master (
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output reg_rdata, ram_rdata,
        input  ack0, ack1, rdata, add, wdata, reg_we, ram_en, ram_we, busy
    );

    modport slave (
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  reg_rdata, ram_rdata,
        output ack0, ack1, rdata, add, wdata, reg_we, ram_en, ram_we, busy
    );
endinterface

// File: rtl/mem_access_sequencer.sv
// Two-port round-robin memory access sequencer. Port 0 is instruction fetch and port 1 is data.
// Addresses below REG_COUNT complete in one cycle through the register bank.
// All other addresses go to RAM and take RAM_WAIT+1 cycles.
// Every output is registered. An ACK pulse follows each access for one cycle in the DONE state.
module mem_access_sequencer #(
    parameter int AW        = 12,
    parameter int DW        = 16,
    parameter int REG_COUNT = 12,
    parameter int RAM_WAIT  = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    mem_access_sequencer_if.slave bus
);

    typedef enum logic [1:0] {S_IDLE, S_REG, S_RAM, S_DONE} state_t;

    localparam logic [AW-1:0] REG_LIMIT = AW'(REG_COUNT);
    localparam logic [3:0]    WAIT_INIT = 4'(RAM_WAIT);

    state_t        state_q;
    logic          last_q;
    logic          port_q;
    logic          we_q;
    logic [3:0]    wcnt_q;
    logic [AW-1:0] add_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          reg_we_q;
    logic          ram_en_q;
    logic          ram_we_q;
    logic          busy_q;

    logic          gnt_vld_d;
    logic          gnt_port_d;
    logic [AW-1:0] gnt_addr_d;
    logic          gnt_we_d;
    logic [DW-1:0] gnt_wdata_d;
    logic          gnt_is_reg_d;

    // Round-robin pick: on a tie, the port that did not win last time is granted.
    always_comb begin
        gnt_vld_d = bus.req0 | bus.req1;
        if (bus.req0 && bus.req1) begin
            gnt_port_d = ~last_q;
        end else begin
            gnt_port_d = bus.req1;
        end
        gnt_addr_d   = gnt_port_d ? bus.addr1  : bus.addr0;
        gnt_we_d     = gnt_port_d ? bus.we1    : bus.we0;
        gnt_wdata_d  = gnt_port_d ? bus.wdata1 : bus.wdata0;
        gnt_is_reg_d = (gnt_addr_d < REG_LIMIT);
    end

    // Access FSM with registered strobes. Reset abandons any access in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            last_q   <= 1'b1;
            port_q   <= 1'b0;
            we_q     <= 1'b0;
            wcnt_q   <= '0;
            add_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            reg_we_q <= 1'b0;
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            reg_we_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (gnt_vld_d) begin
                        port_q  <= gnt_port_d;
                        we_q    <= gnt_we_d;
                        add_q   <= gnt_addr_d;
                        wdata_q <= gnt_wdata_d;
                        wcnt_q  <= WAIT_INIT;
                        busy_q  <= 1'b1;
                        if (gnt_is_reg_d) begin
                            state_q  <= S_REG;
                            reg_we_q <= gnt_we_d;
                        end else begin
                            state_q  <= S_RAM;
                            ram_en_q <= 1'b1;
                            ram_we_q <= gnt_we_d;
                        end
                    end
                end
                S_REG: begin
                    if (!we_q) begin
                        rdata_q <= bus.reg_rdata;
                    end
                    ack0_q  <= ~port_q;
                    ack1_q  <= port_q;
                    state_q <= S_DONE;
                end
                S_RAM: begin
                    if (wcnt_q == 4'd0) begin
                        if (!we_q) begin
                            rdata_q <= bus.ram_rdata;
                        end
                        ram_en_q <= 1'b0;
                        ram_we_q <= 1'b0;
                        ack0_q   <= ~port_q;
                        ack1_q   <= port_q;
                        state_q  <= S_DONE;
                    end else begin
                        wcnt_q <= wcnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    last_q  <= port_q;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0   = ack0_q;
    assign bus.ack1   = ack1_q;
    assign bus.rdata  = rdata_q;
    assign bus.add    = add_q;
    assign bus.wdata  = wdata_q;
    assign bus.reg_we = reg_we_q;
    assign bus.ram_en = ram_en_q;
    assign bus.ram_we = ram_we_q;
    assign bus.busy   = busy_q;

endmodule
